alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the operand width of a and b.
REQ-002 SHALL have parameter RESULT_WIDTH, fixed at 2*DATA_WIDTH, the result width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port alu_rst, input, 1 bit: synchronous soft reset, active-high.
REQ-006 SHALL have port valid, input, 1 bit: request present from the alu_in initiator.
REQ-007 SHALL have port ready, output, 1 bit: core can accept a request.
REQ-008 SHALL have port alu_op, input, 3 bits: operation code.
REQ-009 SHALL have port a, input, DATA_WIDTH bits: operand A, unsigned.
REQ-010 SHALL have port b, input, DATA_WIDTH bits: operand B, unsigned.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-012 SHALL have port result, output, RESULT_WIDTH bits: operation result.

Function
REQ-013 SHALL decode alu_op as follows:
- 000 no_op
- 001 add_op
- 010 and_op
- 011 xor_op
- 100 mul_op
- 111 rst_op
- 101 and 110 treated as no_op
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE; ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a request at rising edge N when valid=1 and ready=1, and capture alu_op, a and b at that edge.
REQ-016 SHALL ignore valid and the operand inputs whenever ready=0.
REQ-017 On an accepted no_op or illegal code, SHALL stay in IDLE, leave result unchanged and not pulse done.
REQ-018 On an accepted rst_op, SHALL clear result to 0 at edge N+1, stay in IDLE and not pulse done.
REQ-019 On an accepted add_op, and_op or xor_op:
- SHALL go IDLE->EXEC at edge N.
- SHALL register result at edge N+1 and go EXEC->DONE.
- result = zero-extended a+b (carry in bit DATA_WIDTH), a&b, or a^b.
REQ-020 On an accepted mul_op:
- SHALL run an iterative shift-add multiply in EXEC, one multiplier bit per cycle.
- SHALL load result = a*b (full RESULT_WIDTH, no truncation) and go EXEC->DONE at edge N+DATA_WIDTH.
- Partial products SHALL NOT be visible on result before done.
REQ-021 SHALL hold done=1 for exactly the one cycle spent in DONE, then return DONE->IDLE with ready=1 at the next edge.
REQ-022 SHALL hold result stable from the done pulse until the next result-producing operation or clear.
REQ-023 Latency from accept edge to done rising SHALL be 1 cycle for add/and/xor and DATA_WIDTH cycles for mul; minimum request spacing SHALL be latency+2 cycles.
REQ-024 alu_rst=1 at any edge SHALL force IDLE, result=0 and done=0, abort any EXEC operation with no done pulse, and take priority over a simultaneous accept.
REQ-025 Back-to-back: a request valid in the same cycle ready returns to 1 SHALL be accepted at that edge.

Reset
REQ-026 While reset=1, SHALL asynchronously force state=IDLE, ready=1, done=0, result=0 and clear the multiply counter and accumulator.
REQ-027 Assertion of reset mid-operation SHALL discard the operation; no done SHALL follow reset release.
REQ-028 After reset deasserts, the first rising edge SHALL be able to accept a request.

Verification (DATA_WIDTH=8)
REQ-029 add_op a=8'hFF b=8'h01 accepted at edge N -> done at edge N+1, result=16'h0100, ready=1 after edge N+2.
REQ-030 mul_op a=8'hFF b=8'hFF -> done exactly 8 cycles after accept, result=16'hFE01; valid pulses while ready=0 are ignored.
REQ-031 xor_op a=8'hA5 b=8'h5A, then rst_op -> result=16'h00FF with a done pulse, then result=16'h0000 with no done.
REQ-032 mul_op a=8'h03 b=8'h04 with alu_rst=1 at accept+3 -> no done, result=0, ready=1 on the next cycle.
REQ-033 reset asserted mid-mul, released, then and_op a=8'hF0 b=8'h3C -> single done, result=16'h0030.
REQ-034 alu_op=3'b101 and no_op -> ready stays 1, no done, result unchanged from the prior value.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: small multi-cycle ALU (add/and/xor, shift-add multiply, result clear).
// Latency: accept edge to done is 1 cycle for add/and/xor and DATA_WIDTH cycles for mul.
// Backpressure: ready is high only in IDLE; valid and operands are ignored while ready is low.
//
// Ports:
//   clock   - single clock, rising edge
//   reset   - asynchronous active-high reset
//   alu_rst - synchronous active-high soft reset (aborts any operation)
//   valid   - request present; accepted when valid && ready at a rising edge
//   ready   - core idle and able to accept a request
//   alu_op  - operation code (000 nop, 001 add, 010 and, 011 xor, 100 mul, 111 clear)
//   a, b    - unsigned operands, DATA_WIDTH bits
//   done    - one-cycle pulse, result valid
//   result  - RESULT_WIDTH-bit result, held until the next result-producing op or clear
module alu_core #(
  parameter  int DATA_WIDTH   = 8,
  localparam int RESULT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alu_rst,
  input  logic                    valid,
  output logic                    ready,
  input  logic [2:0]              alu_op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [RESULT_WIDTH-1:0] result
);

  // Operation codes; 101 and 110 fall through to no-op handling.
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  // FSM encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Multiply step counter: counts 0..DATA_WIDTH-1, one multiplier bit per step.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [1:0]              state;
  logic [2:0]              op_q;
  // a_q doubles as the multiplicand and is shifted left each multiply step,
  // so it is kept at full result width.
  logic [RESULT_WIDTH-1:0] a_q;
  // b_q doubles as the multiplier and is shifted right each multiply step.
  logic [DATA_WIDTH-1:0]   b_q;
  logic [RESULT_WIDTH-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  // A clear request takes effect one edge after it is accepted while the
  // core stays in IDLE, so it is remembered across that edge here.
  logic                    clr_pend;

  logic [RESULT_WIDTH-1:0] acc_next;

  // Partial product accumulation for the current multiplier bit.
  assign acc_next = acc + (b_q[0] ? a_q : '0);

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      clr_pend <= 1'b0;
      result   <= '0;
    end else if (alu_rst) begin
      // Soft reset wins over any accept or in-flight operation.
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      clr_pend <= 1'b0;
      result   <= '0;
    end else begin
      clr_pend <= 1'b0;
      if (clr_pend) begin
        result <= '0;
      end

      case (state)
        IDLE: begin
          if (valid) begin
            case (alu_op)
              OP_ADD, OP_AND, OP_XOR: begin
                op_q  <= alu_op;
                a_q   <= RESULT_WIDTH'(a);
                b_q   <= b;
                state <= EXEC;
              end
              OP_MUL: begin
                op_q  <= alu_op;
                a_q   <= RESULT_WIDTH'(a);
                b_q   <= b;
                acc   <= '0;
                cnt   <= '0;
                state <= EXEC;
              end
              OP_RST: begin
                clr_pend <= 1'b1;
              end
              default: begin
                // no-op and unused codes: nothing changes
              end
            endcase
          end
        end

        EXEC: begin
          case (op_q)
            OP_ADD: begin
              result <= a_q + RESULT_WIDTH'(b_q);
              state  <= DONE;
            end
            OP_AND: begin
              result <= a_q & RESULT_WIDTH'(b_q);
              state  <= DONE;
            end
            OP_XOR: begin
              result <= a_q ^ RESULT_WIDTH'(b_q);
              state  <= DONE;
            end
            OP_MUL: begin
              // The accumulator stays internal; result is loaded only on
              // the final step so partial products never appear on it.
              if (cnt == CNT_LAST) begin
                result <= acc_next;
                state  <= DONE;
              end else begin
                acc <= acc_next;
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end

        default: begin
          // DONE lasts exactly one cycle.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core at DATA_WIDTH=8; expected values computed by hand.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that point.
// Every comparison is an immediate assertion that counts and reports its failure.
module tb_alu_core;

  logic        clock;
  logic        reset;
  logic        alu_rst;
  logic        valid;
  logic        ready;
  logic [2:0]  alu_op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        done;
  logic [15:0] result;

  int n_checks;
  int n_fail;

  alu_core #(.DATA_WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .alu_rst (alu_rst),
    .valid   (valid),
    .ready   (ready),
    .alu_op  (alu_op),
    .a       (a),
    .b       (b),
    .done    (done),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
    valid  = 1'b1;
    alu_op = op;
    a      = va;
    b      = vb;
  endtask

  task automatic idle_inputs();
    valid  = 1'b0;
    alu_op = 3'b000;
    a      = 8'h00;
    b      = 8'h00;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    alu_rst  = 1'b0;
    idle_inputs();

    // Reset state
    #2;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'h0000);
    tick();
    reset = 1'b0;

    // add FF+01: carry lands in bit 8
    req(3'b001, 8'hFF, 8'h01);
    tick();                                  // accept edge N
    idle_inputs();
    chk("add_exec_ready", 16'(ready), 16'd0);
    chk("add_exec_done", 16'(done), 16'd0);
    tick();                                  // N+1
    chk("add_done", 16'(done), 16'd1);
    chk("add_result", result, 16'h0100);
    chk("add_done_ready", 16'(ready), 16'd0);
    tick();                                  // N+2
    chk("add_after_done", 16'(done), 16'd0);
    chk("add_after_ready", 16'(ready), 16'd1);
    chk("add_hold_result", result, 16'h0100);

    // mul FF*FF with spurious valid pulses while busy
    req(3'b100, 8'hFF, 8'hFF);
    tick();                                  // accept edge N
    req(3'b001, 8'h11, 8'h22);               // must be ignored
    for (int i = 1; i < 8; i++) begin
      tick();                                // N+1 .. N+7
      chk("mul_busy_done", 16'(done), 16'd0);
      chk("mul_busy_ready", 16'(ready), 16'd0);
      chk("mul_no_partial", result, 16'h0100);
      valid = ~valid;
    end
    idle_inputs();
    tick();                                  // N+8
    chk("mul_done", 16'(done), 16'd1);
    chk("mul_result", result, 16'hFE01);
    tick();
    chk("mul_after_done", 16'(done), 16'd0);
    chk("mul_after_ready", 16'(ready), 16'd1);
    chk("mul_hold_result", result, 16'hFE01);

    // xor A5^5A, then clear op held valid from the DONE cycle (back-to-back)
    req(3'b011, 8'hA5, 8'h5A);
    tick();
    req(3'b111, 8'h00, 8'h00);
    chk("xor_exec_ready", 16'(ready), 16'd0);
    tick();
    chk("xor_done", 16'(done), 16'd1);
    chk("xor_result", result, 16'h00FF);
    tick();                                  // DONE->IDLE, clear not yet accepted
    chk("clr_wait_ready", 16'(ready), 16'd1);
    chk("clr_wait_result", result, 16'h00FF);
    tick();                                  // clear accepted at this edge
    idle_inputs();
    chk("clr_acc_ready", 16'(ready), 16'd1);
    chk("clr_acc_done", 16'(done), 16'd0);
    chk("clr_acc_result", result, 16'h00FF);
    tick();                                  // cleared one edge later
    chk("clr_result", result, 16'h0000);
    chk("clr_no_done", 16'(done), 16'd0);
    chk("clr_ready", 16'(ready), 16'd1);

    // add 01+01 to get a nonzero result, then mul 3*4 aborted by alu_rst at accept+3
    req(3'b001, 8'h01, 8'h01);
    tick();
    idle_inputs();
    tick();
    chk("add2_result", result, 16'h0002);
    tick();
    req(3'b100, 8'h03, 8'h04);
    tick();                                  // accept edge N
    idle_inputs();
    tick();                                  // N+1
    tick();                                  // N+2
    alu_rst = 1'b1;
    tick();                                  // N+3
    alu_rst = 1'b0;
    chk("abort_ready", 16'(ready), 16'd1);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_result", result, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_done", 16'(done), 16'd0);
    end

    // alu_rst beats a simultaneous accept
    req(3'b001, 8'h05, 8'h05);
    alu_rst = 1'b1;
    tick();
    alu_rst = 1'b0;
    idle_inputs();
    chk("rst_prio_ready", 16'(ready), 16'd1);
    tick();
    chk("rst_prio_done", 16'(done), 16'd0);
    chk("rst_prio_result", result, 16'h0000);

    // reset asserted mid-mul, then and F0&3C on the first edge after release
    req(3'b100, 8'h0F, 8'h0F);
    tick();
    idle_inputs();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("arst_ready", 16'(ready), 16'd1);
    chk("arst_done", 16'(done), 16'd0);
    chk("arst_result", result, 16'h0000);
    tick();                                  // edge while reset held
    #2;
    reset = 1'b0;
    req(3'b010, 8'hF0, 8'h3C);
    tick();                                  // first edge after release accepts
    idle_inputs();
    chk("and_exec_ready", 16'(ready), 16'd0);
    chk("and_exec_done", 16'(done), 16'd0);
    tick();
    chk("and_done", 16'(done), 16'd1);
    chk("and_result", result, 16'h0030);
    tick();
    chk("and_single_done", 16'(done), 16'd0);
    chk("and_ready", 16'(ready), 16'd1);

    // unused code 101 and no-op: no state change
    req(3'b101, 8'hFF, 8'hFF);
    tick();
    chk("op101_ready", 16'(ready), 16'd1);
    chk("op101_done", 16'(done), 16'd0);
    chk("op101_result", result, 16'h0030);
    req(3'b000, 8'h12, 8'h34);
    tick();
    idle_inputs();
    chk("nop_ready", 16'(ready), 16'd1);
    chk("nop_done", 16'(done), 16'd0);
    tick();
    chk("nop_late_done", 16'(done), 16'd0);
    chk("nop_result", result, 16'h0030);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
